dcache_miss_handler: RTL and testbench

//  Sits directly upstream of the single-line DataCache. Accepts word-load requests,

---
 rtl/dc_pkg.sv | 25 ++
 rtl/dc_word_select.sv | 21 ++
 rtl/dcache_miss_handler.sv | 151 +++++++++++++++
 tb/tb_dcache_miss_handler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared types and geometry for the data-cache miss handler.
package dc_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned LineW = 512;
  localparam int unsigned WordW = 16;

  localparam int unsigned OB  = $clog2(LineW / 8);  // line offset bits
  localparam int unsigned WB  = $clog2(WordW / 8);  // byte-in-word bits
  localparam int unsigned WIB = OB - WB;            // word index bits

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCheck,
    StMreq,
    StMwait,
    StResp
  } dc_state_e;

  function automatic logic [AddrW-1:0] line_addr(input logic [AddrW-1:0] addr);
    return {addr[AddrW-1:OB], {OB{1'b0}}};
  endfunction

endpackage

// File: rtl/dc_word_select.sv
// Combinational word extraction from a cache line by word index.
module dc_word_select #(
  parameter int unsigned DATAW = dc_pkg::WordW,
  parameter int unsigned INW   = dc_pkg::LineW,
  parameter int unsigned IDXW  = dc_pkg::WIB
) (
  input  logic [INW-1:0]   line,
  input  logic [IDXW-1:0]  idx,
  output logic [DATAW-1:0] word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < (1 << IDXW); i++) begin
      if (idx == i[IDXW-1:0]) begin
        word = line[i*DATAW +: DATAW];
      end
    end
  end

endmodule

// File: rtl/dcache_miss_handler.sv
// Load front-end for a single-line data cache: lookup, miss fill from memory, word return.
module dcache_miss_handler
  import dc_pkg::*;
#(
  parameter int unsigned DATAW = 16,
  parameter int unsigned INW   = 512,
  parameter int unsigned ADDRW = 32,
  parameter int unsigned CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDRW-1:0] req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATAW-1:0] rsp_data,
  output logic [ADDRW-1:0] cache_addr,
  input  logic             cache_hit,
  input  logic [INW-1:0]   cache_line,
  output logic             cache_write,
  output logic [INW-1:0]   cache_wdata,
  output logic             mem_rd_req,
  output logic [ADDRW-1:0] mem_rd_addr,
  input  logic             mem_rd_gnt,
  input  logic             mem_rd_valid,
  input  logic [INW-1:0]   mem_rd_data,
  output logic [CNTW-1:0]  hit_count,
  output logic [CNTW-1:0]  miss_count
);

  localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

  dc_state_e        state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW-1:0] cache_addr_q, cache_addr_d;
  logic [DATAW-1:0] rsp_data_q, rsp_data_d;
  logic [CNTW-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNTW-1:0]  miss_cnt_q, miss_cnt_d;
  logic             fill;

  logic [WIB-1:0]   word_idx;
  logic [DATAW-1:0] hit_word;
  logic [DATAW-1:0] fill_word;

  assign word_idx = addr_q[OB-1:WB];

  dc_word_select #(
    .DATAW (DATAW),
    .INW   (INW),
    .IDXW  (WIB)
  ) u_sel_hit (
    .line (cache_line),
    .idx  (word_idx),
    .word (hit_word)
  );

  dc_word_select #(
    .DATAW (DATAW),
    .INW   (INW),
    .IDXW  (WIB)
  ) u_sel_fill (
    .line (mem_rd_data),
    .idx  (word_idx),
    .word (fill_word)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cache_addr_d = cache_addr_q;
    rsp_data_d   = rsp_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    fill         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d       = req_addr;
          cache_addr_d = line_addr(req_addr);
          state_d      = StLookup;
        end
      end
      // Cache output is registered: wait one cycle for it to reflect the new address.
      StLookup: state_d = StCheck;
      StCheck: begin
        if (cache_hit) begin
          rsp_data_d = hit_word;
          hit_cnt_d  = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CntOne;
          state_d    = StResp;
        end else begin
          miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CntOne;
          state_d    = StMreq;
        end
      end
      StMreq: begin
        if (mem_rd_gnt) begin
          if (mem_rd_valid) begin
            fill       = 1'b1;
            rsp_data_d = fill_word;
            state_d    = StResp;
          end else begin
            state_d = StMwait;
          end
        end
      end
      StMwait: begin
        if (mem_rd_valid) begin
          fill       = 1'b1;
          rsp_data_d = fill_word;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cache_addr_q <= '0;
      rsp_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cache_addr_q <= cache_addr_d;
      rsp_data_q   <= rsp_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign cache_addr  = cache_addr_q;
  assign cache_write = fill;
  assign cache_wdata = fill ? mem_rd_data : '0;
  assign mem_rd_req  = (state_q == StMreq);
  assign mem_rd_addr = line_addr(addr_q);
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Directed plus randomized load sequence against a single-line cache and memory model.
module tb_dcache_miss_handler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [15:0]  rsp_data;
  logic [31:0]  cache_addr;
  logic         cache_hit;
  logic [511:0] cache_line;
  logic         cache_write;
  logic [511:0] cache_wdata;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_gnt;
  logic         mem_rd_valid;
  logic [511:0] mem_rd_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int vecs = 0;
  int errs = 0;

  // Reference state: which line is resident and how many hits/misses so far.
  bit           ref_valid = 1'b0;
  logic [31:0]  ref_line  = '0;
  int           exp_hits  = 0;
  int           exp_miss  = 0;
  logic [511:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  dcache_miss_handler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .cache_addr   (cache_addr),
    .cache_hit    (cache_hit),
    .cache_line   (cache_line),
    .cache_write  (cache_write),
    .cache_wdata  (cache_wdata),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_gnt   (mem_rd_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  // Single-line cache with registered lookup outputs.
  logic         cm_valid = 1'b0;
  logic [31:0]  cm_tag   = '0;
  logic [511:0] cm_data  = '0;
  initial begin
    cache_hit  = 1'b0;
    cache_line = '0;
  end
  always @(posedge clk) begin
    if (cache_write) begin
      cm_valid <= 1'b1;
      cm_tag   <= cache_addr;
      cm_data  <= cache_wdata;
    end
    cache_hit  <= cm_valid && (cm_tag == cache_addr);
    cache_line <= cm_data;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_line(input logic [31:0] la, output logic [511:0] l);
    logic [511:0] tmp;
    if (!mem.exists(la)) begin
      for (int k = 0; k < 16; k++) tmp[k*32 +: 32] = $urandom;
      mem[la] = tmp;
    end
    l = mem[la];
  endtask

  task automatic check_counters();
    chk("hit_count", 512'(hit_count), 512'(exp_hits));
    chk("miss_count", 512'(miss_count), 512'(exp_miss));
  endtask

  task automatic do_req(input logic [31:0] addr, input int gnt_dly, input bit coincide,
                        input int data_dly, input int bp);
    logic [31:0]  la;
    logic [511:0] l;
    logic [15:0]  exp_word;
    bit           exp_hit, granted, fed, done;
    int           wi, t, exp_t, rq_cycles, wait_cycles, writes;
    la = addr & 32'hFFFF_FFC0;
    get_line(la, l);
    wi       = int'((addr >> 1) & 32'd31);
    exp_word = l[wi*16 +: 16];
    exp_hit  = ref_valid && (ref_line == la);
    exp_t    = exp_hit ? 3 : (coincide ? 4 + gnt_dly : 5 + gnt_dly + data_dly);
    granted = 1'b0; fed = 1'b0; done = 1'b0;
    t = 0; rq_cycles = 0; wait_cycles = 0; writes = 0;

    @(negedge clk);
    chk("req_ready_idle", 512'(req_ready), 512'(1));
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
      mem_rd_gnt   = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_data  = {16{$urandom}};
      if (mem_rd_req) begin
        rq_cycles++;
        if (rq_cycles == 1) chk("mem_rd_addr", 512'(mem_rd_addr), 512'(la));
        if (rq_cycles > gnt_dly) begin
          mem_rd_gnt = 1'b1;
          granted    = 1'b1;
          if (coincide) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = l;
            fed          = 1'b1;
          end
        end
      end else if (granted && !fed && !rsp_valid) begin
        wait_cycles++;
        if (wait_cycles > data_dly) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = l;
          fed          = 1'b1;
        end
      end
      #1;
      if (cache_write) begin
        writes++;
        chk("cache_wdata", cache_wdata, l);
        chk("cache_addr_fill", 512'(cache_addr), 512'(la));
      end
      if (rsp_valid) begin
        chk("rsp_latency", 512'(t), 512'(exp_t));
        chk("rsp_data", 512'(rsp_data), 512'(exp_word));
        for (int i = 0; i < bp; i++) begin
          @(negedge clk);
          chk("bp_rsp_valid", 512'(rsp_valid), 512'(1));
          chk("bp_rsp_data", 512'(rsp_data), 512'(exp_word));
          chk("bp_req_ready", 512'(req_ready), 512'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        done      = 1'b1;
      end
    end
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    chk("rsp_seen", 512'(done), 512'(1));
    chk("req_ready_after", 512'(req_ready), 512'(1));
    chk("cache_writes", 512'(writes), 512'(exp_hit ? 0 : 1));
    chk("mem_req_issued", 512'(rq_cycles > 0), 512'(!exp_hit));
    if (exp_hit) exp_hits++;
    else begin
      exp_miss++;
      ref_valid = 1'b1;
      ref_line  = la;
    end
    check_counters();
  endtask

  initial begin
    logic [511:0] tmp;
    logic [511:0] l;
    logic [31:0]  a;
    bit           seen;

    for (int k = 0; k < 16; k++) tmp[k*32 +: 32] = $urandom;
    tmp[31:16]    = 16'hBEEF;
    mem[32'h40]   = tmp;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    rsp_ready    = 1'b0;
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
    chk("rst_rsp_data", 512'(rsp_data), 512'(0));
    chk("rst_mem_rd_req", 512'(mem_rd_req), 512'(0));
    chk("rst_mem_rd_addr", 512'(mem_rd_addr), 512'(0));
    chk("rst_cache_write", 512'(cache_write), 512'(0));
    chk("rst_cache_wdata", cache_wdata, 512'(0));
    chk("rst_cache_addr", 512'(cache_addr), 512'(0));
    chk("rst_req_ready", 512'(req_ready), 512'(1));
    check_counters();

    do_req(32'h0000_0042, 0, 1'b0, 0, 0);   // cold miss, word[1] = BEEF
    chk("cold_rsp_beef", 512'(rsp_data), 512'(16'hBEEF));
    do_req(32'h0000_007E, 0, 1'b0, 0, 0);   // hit on word[31]
    do_req(32'h0000_0080, 1, 1'b0, 2, 0);   // conflict miss
    do_req(32'h0000_0084, 0, 1'b0, 0, 5);   // hit with backpressure
    do_req(32'h0000_00C6, 4, 1'b1, 0, 1);   // grant delay, data with grant

    for (int n = 0; n < 16; n++) begin
      a = 32'h100 + (32'($urandom_range(0, 2)) << 6) + 32'($urandom_range(0, 63));
      do_req(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Abort a miss in MWAIT with reset, then offer a stale beat.
    get_line(32'h1C0, l);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h1C4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd_req) seen = 1'b1;
    end
    chk("abort_mem_rd_req", 512'(seen), 512'(1));
    mem_rd_gnt = 1'b1;
    @(negedge clk);
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data  = l;
    #1;
    chk("abort_fill_pending", 512'(cache_write), 512'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_cache_write", 512'(cache_write), 512'(0));
    chk("abort_mem_req", 512'(mem_rd_req), 512'(0));
    chk("abort_rsp_valid", 512'(rsp_valid), 512'(0));
    chk("abort_mem_rd_addr", 512'(mem_rd_addr), 512'(0));
    chk("abort_cache_addr", 512'(cache_addr), 512'(0));
    exp_hits = 0;
    exp_miss = 0;
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stray_cache_write", 512'(cache_write), 512'(0));
      chk("stray_rsp_valid", 512'(rsp_valid), 512'(0));
      chk("stray_req_ready", 512'(req_ready), 512'(1));
    end
    mem_rd_valid = 1'b0;

    do_req(ref_line + 32'd6, 0, 1'b0, 0, 0);  // resident line survives handler reset
    do_req(32'h0000_0042, 2, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
